// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: bus widths, ALU opcodes,
// token kinds and the sequencer state encoding.
package calc_pkg;

  localparam int CALC_WIDTH = 8;
  localparam int CALC_OPW   = 3;

  localparam logic [CALC_OPW-1:0] OP_ADD = 3'b000;
  localparam logic [CALC_OPW-1:0] OP_SUB = 3'b001;
  localparam logic [CALC_OPW-1:0] OP_AND = 3'b010;
  localparam logic [CALC_OPW-1:0] OP_OR  = 3'b011;
  localparam logic [CALC_OPW-1:0] OP_XOR = 3'b100;

  localparam logic [1:0] KIND_OPERAND  = 2'b00;
  localparam logic [1:0] KIND_OPERATOR = 2'b01;
  localparam logic [1:0] KIND_EQUALS   = 2'b10;
  localparam logic [1:0] KIND_CLEAR    = 2'b11;

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_ACC   = 3'd1,
    S_OP    = 3'd2,
    S_EXEC  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Token input, ALU and result buses of the calculator sequencer.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// the producer holds valid and its payload stable until that edge.
interface calc_sequencer_if #(
  parameter int WIDTH = calc_pkg::CALC_WIDTH,
  parameter int OPW   = calc_pkg::CALC_OPW
);
  import calc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_kind;
  logic [WIDTH-1:0] in_data;

  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_Result;
  logic             alu_Zero;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_ovf;
  logic             err;

  state_t           dbg_state;

  modport master (
    input  in_valid, in_kind, in_data, alu_Result, alu_Zero, res_ready,
    output in_ready, alu_A, alu_B, alu_opcode,
           res_valid, res_data, res_zero, res_ovf, err, dbg_state
  );

  modport slave (
    output in_valid, in_kind, in_data, alu_Result, alu_Zero, res_ready,
    input  in_ready, alu_A, alu_B, alu_opcode,
           res_valid, res_data, res_zero, res_ovf, err, dbg_state
  );

endinterface

// File: rtl/calc_sequencer.sv
// Keypad-token sequencer driving an external combinational ALU with a running accumulator.
// Optional CALC_OVF_EN: tracks carry/borrow of ADD/SUB across a chain on res_ovf.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int OPW   = CALC_OPW
) (
  input  logic            clk,
  input  logic            rst,
  calc_sequencer_if.master bus
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             zero_q;
  logic [OPW-1:0]   op_q;
  logic             accept;

  assign bus.in_ready  = (state == S_EMPTY) || (state == S_ACC) || (state == S_OP);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_EMPTY;
      acc            <= '0;
      zero_q         <= 1'b0;
      op_q           <= '0;
      bus.alu_A      <= '0;
      bus.alu_B      <= '0;
      bus.alu_opcode <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_zero   <= 1'b0;
      bus.err        <= 1'b0;
    end else if (accept && bus.in_kind == KIND_CLEAR) begin
      state   <= S_EMPTY;
      acc     <= '0;
      zero_q  <= 1'b1;
      bus.err <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: if (accept) begin
          if (bus.in_kind == KIND_OPERAND) begin
            acc    <= bus.in_data;
            zero_q <= (bus.in_data == '0);
            state  <= S_ACC;
          end else begin
            bus.err <= 1'b1;
          end
        end
        S_ACC: if (accept) begin
          if (bus.in_kind == KIND_OPERATOR) begin
            op_q  <= bus.in_data[OPW-1:0];
            state <= S_OP;
          end else if (bus.in_kind == KIND_EQUALS) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= acc;
            bus.res_zero  <= zero_q;
            state         <= S_OUT;
          end else begin
            bus.err <= 1'b1;
          end
        end
        S_OP: if (accept) begin
          if (bus.in_kind == KIND_OPERAND) begin
            bus.alu_A      <= acc;
            bus.alu_B      <= bus.in_data;
            bus.alu_opcode <= op_q;
            state          <= S_EXEC;
          end else if (bus.in_kind == KIND_OPERATOR) begin
            op_q <= bus.in_data[OPW-1:0];
          end else begin
            // EQUALS with an operator pending: drop the operator, keep acc
            bus.err <= 1'b1;
            state   <= S_ACC;
          end
        end
        S_EXEC: begin
          acc    <= bus.alu_Result;
          zero_q <= bus.alu_Zero;
          state  <= S_ACC;
        end
        S_OUT: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          state         <= S_ACC;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

`ifdef CALC_OVF_EN
  logic             ovf_q;
  logic [WIDTH:0]   sum;
  logic             carry;

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, bus.alu_B};
    carry = 1'b0;
    if (bus.alu_opcode == OP_ADD)      carry = sum[WIDTH];
    else if (bus.alu_opcode == OP_SUB) carry = (acc < bus.alu_B);
  end

  // A fresh chain starts at CLEAR or at the first operand after S_EMPTY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept && (bus.in_kind == KIND_CLEAR ||
                            (state == S_EMPTY && bus.in_kind == KIND_OPERAND))) begin
      ovf_q <= 1'b0;
    end else if (state == S_EXEC) begin
      ovf_q <= ovf_q | carry;
    end
  end

  assign bus.res_ovf = ovf_q;
`else
  assign bus.res_ovf = 1'b0;
`endif

endmodule
